// File: rtl/dma_arbiter_pkg.sv
// Shared definitions for the two-requester iDMA command arbiter.
// Holds the requester-ID width, the default queue depth and FSM encodings.
package dma_arbiter_pkg;

    localparam int ID_W      = 1;
    localparam int DEPTH_DEF = 4;

    typedef logic [ID_W-1:0] id_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } state_e;

endpackage

// File: rtl/dma_id_fifo.sv
// In-order queue of requester IDs for issued, uncompleted iDMA commands.
// Ports: push/push_id write, pop read, head/empty/count status.
module dma_id_fifo
    import dma_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     push,
    input  id_t                      push_id,
    input  logic                     pop,
    output id_t                      head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    id_t            mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  cnt;
    logic           do_push;
    logic           do_pop;

    assign empty   = (cnt == '0);
    assign do_push = push && (cnt != CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign count   = cnt;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage needs no reset: entries are only read below the count.
    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= push_id;
    end

endmodule

// File: rtl/dma_arbiter.sv
// Round-robin arbiter of two requesters onto one iDMA command port, with
// completions routed back by an in-order ID queue.
// Ports: r0_*/r1_* requester command and completion handshakes, rpt_*_o
// broadcast completion fields, dma_* registered iDMA command, rpt_* iDMA
// completion input, outstanding = issued but uncompleted commands.
module dma_arbiter
    import dma_arbiter_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [15:0]              r0_src_addr,
    input  logic [63:0]              r0_dst_addr,
    input  logic [15:0]              r0_bytes,
    input  logic                     r0_valid,
    output logic                     r0_ready,
    output logic                     r0_rpt_valid,
    input  logic                     r0_rpt_ready,
    input  logic [15:0]              r1_src_addr,
    input  logic [63:0]              r1_dst_addr,
    input  logic [15:0]              r1_bytes,
    input  logic                     r1_valid,
    output logic                     r1_ready,
    output logic                     r1_rpt_valid,
    input  logic                     r1_rpt_ready,
    output logic [15:0]              rpt_src_addr_o,
    output logic [63:0]              rpt_dst_addr_o,
    output logic [15:0]              rpt_bytes_o,
    output logic [15:0]              dma_src_addr,
    output logic [63:0]              dma_dst_addr,
    output logic [15:0]              dma_bytes,
    output logic                     dma_valid,
    input  logic                     dma_ready,
    input  logic [15:0]              rpt_src_addr,
    input  logic [63:0]              rpt_dst_addr,
    input  logic [15:0]              rpt_bytes,
    input  logic                     rpt_valid,
    output logic                     rpt_ready,
    output logic [$clog2(DEPTH):0]   outstanding
);

    localparam int CW = $clog2(DEPTH) + 1;

    state_e state;
    state_e state_nxt;
    id_t    last_id;
    id_t    issue_id;
    id_t    grant_id;
    logic   grant_vld;
    logic   can_grant;
    logic   req_fire;
    logic   push;
    logic   pop;
    id_t    head;
    logic   empty;

    // Contention goes to the requester that did not win last time.
    always_comb begin
        grant_id  = '0;
        grant_vld = 1'b0;
        if (r0_valid && r1_valid) begin
            grant_vld = 1'b1;
            grant_id  = ~last_id;
        end else if (r0_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b0;
        end else if (r1_valid) begin
            grant_vld = 1'b1;
            grant_id  = 1'b1;
        end
    end

    assign can_grant = (state == S_IDLE) && (outstanding < CW'(DEPTH));
    assign r0_ready  = can_grant && grant_vld && (grant_id == 1'b0);
    assign r1_ready  = can_grant && grant_vld && (grant_id == 1'b1);
    assign req_fire  = can_grant && grant_vld;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= S_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        push      = 1'b0;
        dma_valid = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_fire) state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                dma_valid = 1'b1;
                if (dma_ready) begin
                    push      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            last_id      <= 1'b1;
            issue_id     <= '0;
            dma_src_addr <= '0;
            dma_dst_addr <= '0;
            dma_bytes    <= '0;
        end else if (req_fire) begin
            last_id      <= grant_id;
            issue_id     <= grant_id;
            dma_src_addr <= grant_id ? r1_src_addr : r0_src_addr;
            dma_dst_addr <= grant_id ? r1_dst_addr : r0_dst_addr;
            dma_bytes    <= grant_id ? r1_bytes    : r0_bytes;
        end
    end

    // The iDMA completes in issue order, so the queue head owns rpt_*.
    assign r0_rpt_valid = rpt_valid && !empty && (head == 1'b0);
    assign r1_rpt_valid = rpt_valid && !empty && (head == 1'b1);
    assign rpt_ready    = !empty && (head ? r1_rpt_ready : r0_rpt_ready);
    assign pop          = rpt_valid && rpt_ready;

    assign rpt_src_addr_o = rpt_src_addr;
    assign rpt_dst_addr_o = rpt_dst_addr;
    assign rpt_bytes_o    = rpt_bytes;

    dma_id_fifo #(
        .DEPTH (DEPTH)
    ) u_id_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push),
        .push_id (issue_id),
        .pop     (pop),
        .head    (head),
        .empty   (empty),
        .count   (outstanding)
    );

endmodule
